// File: rtl/ide_sector_sequencer.sv
// IDE READ/WRITE SECTORS command engine: moves one 512-byte sector at a time between
// the shared sector RAM and a byte-stream storage backend, reporting BSY/DRQ/IRQ/ERR.
module ide_sector_sequencer #(
    parameter logic [7:0] CMD_READ  = 8'h20,
    parameter logic [7:0] CMD_WRITE = 8'h30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_op,
    input  logic [27:0] cmd_lba,
    input  logic [7:0]  cmd_count,
    input  logic        host_done,
    output logic        bsy,
    output logic        drq,
    output logic        irq,
    output logic        err,
    output logic [8:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        st_req,
    output logic        st_write,
    output logic [27:0] st_lba,
    input  logic        st_ack,
    input  logic        st_rd_valid,
    input  logic [7:0]  st_rd_data,
    output logic        st_wr_valid,
    output logic [7:0]  st_wr_data,
    input  logic        st_wr_ready,
    input  logic        st_done,
    input  logic        st_err
);

    typedef enum logic [2:0] {
        IDLE, REQ, RD_XFER, RD_HOST, WR_HOST, WR_FETCH, WR_XFER, WR_COMMIT
    } state_t;

    state_t      state, state_n;
    logic [27:0] lba, lba_n;
    logic [8:0]  remaining, remaining_n;
    logic        is_write, is_write_n;
    logic        fetch_wait, fetch_wait_n;
    logic        bsy_n, drq_n, irq_n, err_n;
    logic [8:0]  addr_n;
    logic        wr_valid_n;
    logic [7:0]  wr_data_n;

    assign st_req    = (state == REQ);
    assign st_write  = is_write;
    assign st_lba    = lba;
    assign ram_we    = (state == RD_XFER) && st_rd_valid && !st_err;
    assign ram_wdata = st_rd_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lba         <= '0;
            remaining   <= '0;
            is_write    <= 1'b0;
            fetch_wait  <= 1'b0;
            bsy         <= 1'b0;
            drq         <= 1'b0;
            irq         <= 1'b0;
            err         <= 1'b0;
            ram_addr    <= '0;
            st_wr_valid <= 1'b0;
            st_wr_data  <= '0;
        end else begin
            state       <= state_n;
            lba         <= lba_n;
            remaining   <= remaining_n;
            is_write    <= is_write_n;
            fetch_wait  <= fetch_wait_n;
            bsy         <= bsy_n;
            drq         <= drq_n;
            irq         <= irq_n;
            err         <= err_n;
            ram_addr    <= addr_n;
            st_wr_valid <= wr_valid_n;
            st_wr_data  <= wr_data_n;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_n      = state;
        lba_n        = lba;
        remaining_n  = remaining;
        is_write_n   = is_write;
        fetch_wait_n = fetch_wait;
        bsy_n        = bsy;
        drq_n        = drq;
        irq_n        = 1'b0;
        err_n        = err;
        addr_n       = ram_addr;
        wr_valid_n   = st_wr_valid;
        wr_data_n    = st_wr_data;

        if (state != IDLE && st_err) begin
            // A storage fault overrides whatever else happens this cycle.
            state_n      = IDLE;
            bsy_n        = 1'b0;
            drq_n        = 1'b0;
            err_n        = 1'b1;
            irq_n        = 1'b1;
            wr_valid_n   = 1'b0;
            fetch_wait_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        err_n       = 1'b0;
                        lba_n       = cmd_lba;
                        remaining_n = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
                        if (cmd_op == CMD_READ) begin
                            bsy_n      = 1'b1;
                            is_write_n = 1'b0;
                            state_n    = REQ;
                        end else if (cmd_op == CMD_WRITE) begin
                            bsy_n      = 1'b1;
                            is_write_n = 1'b1;
                            drq_n      = 1'b1;
                            state_n    = WR_HOST;
                        end else begin
                            err_n = 1'b1;
                            irq_n = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (st_ack) begin
                        addr_n       = '0;
                        fetch_wait_n = 1'b0;
                        state_n      = is_write ? WR_FETCH : RD_XFER;
                    end
                end
                RD_XFER: begin
                    if (st_rd_valid) begin
                        addr_n = ram_addr + 9'd1;
                        if (ram_addr == 9'd511) begin
                            drq_n   = 1'b1;
                            irq_n   = 1'b1;
                            state_n = RD_HOST;
                        end
                    end
                end
                RD_HOST: begin
                    if (host_done) begin
                        drq_n       = 1'b0;
                        remaining_n = remaining - 9'd1;
                        lba_n       = lba + 28'd1;
                        if (remaining == 9'd1) begin
                            bsy_n   = 1'b0;
                            state_n = IDLE;
                        end else begin
                            state_n = REQ;
                        end
                    end
                end
                WR_HOST: begin
                    if (host_done) begin
                        drq_n   = 1'b0;
                        state_n = REQ;
                    end
                end
                WR_FETCH: begin
                    // First cycle presents the address; the RAM answers on the second.
                    if (!fetch_wait) begin
                        fetch_wait_n = 1'b1;
                    end else begin
                        fetch_wait_n = 1'b0;
                        wr_data_n    = ram_rdata;
                        wr_valid_n   = 1'b1;
                        state_n      = WR_XFER;
                    end
                end
                WR_XFER: begin
                    if (st_wr_valid && st_wr_ready) begin
                        wr_valid_n = 1'b0;
                        addr_n     = ram_addr + 9'd1;
                        state_n    = (ram_addr == 9'd511) ? WR_COMMIT : WR_FETCH;
                    end
                end
                WR_COMMIT: begin
                    if (st_done) begin
                        remaining_n = remaining - 9'd1;
                        lba_n       = lba + 28'd1;
                        if (remaining == 9'd1) begin
                            bsy_n   = 1'b0;
                            irq_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            drq_n   = 1'b1;
                            state_n = WR_HOST;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ide_sector_sequencer.sv
// Self-checking bench for ide_sector_sequencer: sector RAM model, randomized storage
// backend and host, with expectations derived from command/sector arithmetic.
module tb_ide_sector_sequencer;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [27:0] cmd_lba;
    logic [7:0]  cmd_count;
    logic        host_done;
    logic        bsy, drq, irq, err;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        st_req, st_write;
    logic [27:0] st_lba;
    logic        st_ack, st_rd_valid;
    logic [7:0]  st_rd_data;
    logic        st_wr_valid;
    logic [7:0]  st_wr_data;
    logic        st_wr_ready, st_done, st_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ide_sector_sequencer #(.CMD_READ(CMD_READ), .CMD_WRITE(CMD_WRITE)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
        .host_done(host_done),
        .bsy(bsy), .drq(drq), .irq(irq), .err(err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .st_req(st_req), .st_write(st_write), .st_lba(st_lba), .st_ack(st_ack),
        .st_rd_valid(st_rd_valid), .st_rd_data(st_rd_data),
        .st_wr_valid(st_wr_valid), .st_wr_data(st_wr_data), .st_wr_ready(st_wr_ready),
        .st_done(st_done), .st_err(st_err)
    );

    // Sector RAM: synchronous read, engine write port, and a one-cycle host bulk fill.
    logic [7:0] mem      [512];
    logic [7:0] fill_buf [512];
    logic [7:0] rd_exp   [512];
    logic [7:0] wr_exp   [512];
    logic       fill_pulse;

    always @(posedge clk) begin
        if (fill_pulse) begin
            for (int i = 0; i < 512; i++) mem[i] <= fill_buf[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int   irq_cnt  = 0;
    int   irq_wide = 0;
    logic irq_q    = 1'b0;

    always @(negedge clk) begin
        irq_q <= irq;
        if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
        if (irq === 1'b1 && irq_q === 1'b1) irq_wide <= irq_wide + 1;
    end

    task automatic issue_cmd(input logic [7:0] op, input logic [27:0] lba, input logic [7:0] count);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_lba   = lba;
        cmd_count = count;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (st_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Plays one storage read: request/ack, then 512 bytes with random gaps.
    task automatic serve_read_sector(input logic [27:0] exp_lba, input int err_at, input bit ramp,
                                     output bit aborted);
        int  bad = 0;
        bit  held_bad = 1'b0;
        bit  early_drq = 1'b0;
        aborted = 1'b0;
        wait_req();
        checks++;
        if (st_req !== 1'b1 || st_lba !== exp_lba || st_write !== 1'b0 || drq !== 1'b0) begin
            errors++;
            $display("FAIL read_req: st_req=%b st_lba=%h st_write=%b drq=%b, want 1 %h 0 0",
                     st_req, st_lba, st_write, drq, exp_lba);
            aborted = 1'b1;
            return;
        end
        repeat ($urandom_range(3)) begin
            @(negedge clk);
            if (st_req !== 1'b1 || st_lba !== exp_lba) held_bad = 1'b1;
        end
        checks++;
        if (held_bad) begin
            errors++;
            $display("FAIL read_req_hold: request or LBA changed before st_ack, want held at %h", exp_lba);
        end
        st_ack    = 1'b1;
        host_done = 1'b1;
        @(negedge clk);
        st_ack    = 1'b0;
        host_done = 1'b0;
        for (int b = 0; b < 512; b++) begin
            while ($urandom_range(3) == 0) begin
                st_rd_valid = 1'b0;
                @(negedge clk);
            end
            rd_exp[b]   = ramp ? b[7:0] : 8'($urandom);
            st_rd_valid = 1'b1;
            st_rd_data  = rd_exp[b];
            st_err      = (b == err_at);
            @(negedge clk);
            st_rd_valid = 1'b0;
            st_err      = 1'b0;
            if (b == err_at) begin
                aborted = 1'b1;
                return;
            end
            if (b < 511 && drq !== 1'b0) early_drq = 1'b1;
        end
        checks++;
        if (drq !== 1'b1 || irq !== 1'b1 || bsy !== 1'b1 || ram_addr !== 9'd0 || early_drq) begin
            errors++;
            $display("FAIL read_sector_end: drq=%b irq=%b bsy=%b ram_addr=%0d early_drq=%b, want 1 1 1 0 0",
                     drq, irq, bsy, ram_addr, early_drq);
        end
        for (int i = 0; i < 512; i++) if (mem[i] !== rd_exp[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL read_ram: %0d bytes differ from streamed data, want 0", bad);
        end
    endtask

    task automatic host_fill(input bit spec_pattern);
        for (int i = 0; i < 512; i++) begin
            fill_buf[i] = spec_pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
            wr_exp[i]   = fill_buf[i];
        end
        fill_pulse = 1'b1;
        @(negedge clk);
        fill_pulse = 1'b0;
    endtask

    task automatic host_drain(input bit exp_bsy);
        bit dropped = 1'b0;
        repeat ($urandom_range(1, 6)) begin
            @(negedge clk);
            if (drq !== 1'b1) dropped = 1'b1;
        end
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
        checks++;
        if (dropped || drq !== 1'b0 || bsy !== exp_bsy) begin
            errors++;
            $display("FAIL host_drain: drq_dropped_early=%b drq=%b bsy=%b, want 0 0 %b",
                     dropped, drq, bsy, exp_bsy);
        end
    endtask

    // Plays one storage write with a randomly toggling ready; bytes checked in order.
    task automatic serve_write_sector(input logic [27:0] exp_lba);
        int         got = 0;
        int         bad = 0;
        int         unstable = 0;
        int         n = 0;
        bit         pend = 1'b0;
        logic [7:0] pend_data = 8'h00;
        wait_req();
        checks++;
        if (st_req !== 1'b1 || st_write !== 1'b1 || st_lba !== exp_lba) begin
            errors++;
            $display("FAIL write_req: st_req=%b st_write=%b st_lba=%h, want 1 1 %h",
                     st_req, st_write, st_lba, exp_lba);
            return;
        end
        st_ack = 1'b1;
        @(negedge clk);
        st_ack = 1'b0;
        while (got < 512 && n < 8000) begin
            st_wr_ready = 1'($urandom_range(1));
            if (pend && (st_wr_valid !== 1'b1 || st_wr_data !== pend_data)) unstable++;
            pend = 1'b0;
            if (st_wr_valid === 1'b1) begin
                if (st_wr_ready) begin
                    if (st_wr_data !== wr_exp[got]) bad++;
                    got++;
                end else begin
                    pend      = 1'b1;
                    pend_data = st_wr_data;
                end
            end
            @(negedge clk);
            n++;
        end
        st_wr_ready = 1'b0;
        checks++;
        if (got != 512 || bad != 0 || unstable != 0) begin
            errors++;
            $display("FAIL write_stream: bytes=%0d wrong=%0d unstable=%0d, want 512 0 0", got, bad, unstable);
        end
    endtask

    task automatic commit_sector(input bit last, input int irq0);
        bit extra = 1'b0;
        repeat ($urandom_range(2, 6)) begin
            @(negedge clk);
            if (st_wr_valid !== 1'b0 || bsy !== 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra || irq_cnt != irq0) begin
            errors++;
            $display("FAIL pre_commit: stray_valid_or_idle=%b irqs=%0d, want 0 0", extra, irq_cnt - irq0);
        end
        st_done = 1'b1;
        @(negedge clk);
        st_done = 1'b0;
        checks++;
        if (bsy !== !last || drq !== !last || irq !== last) begin
            errors++;
            $display("FAIL commit: bsy=%b drq=%b irq=%b, want %b %b %b", bsy, drq, irq, !last, !last, last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bsy !== 0 || drq !== 0 || irq !== 0 || err !== 0 || st_req !== 0 || st_wr_valid !== 0 ||
            ram_we !== 0 || ram_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset: bsy=%b drq=%b irq=%b err=%b st_req=%b wr_valid=%b ram_we=%b addr=%0d, want all 0",
                     bsy, drq, irq, err, st_req, st_wr_valid, ram_we, ram_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_basic();
        int irq0 = irq_cnt;
        bit ab;
        issue_cmd(CMD_READ, 28'h0000123, 8'd1);
        checks++;
        if (bsy !== 1'b1 || err !== 1'b0 || drq !== 1'b0) begin
            errors++;
            $display("FAIL read_start: bsy=%b err=%b drq=%b, want 1 0 0", bsy, err, drq);
        end
        serve_read_sector(28'h0000123, -1, 1'b1, ab);
        host_drain(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 1) begin
            errors++;
            $display("FAIL read_basic_irqs: %0d pulses, want 1", irq_cnt - irq0);
        end
    endtask

    task automatic test_read_lba_wrap();
        int irq0 = irq_cnt;
        bit ab;
        issue_cmd(CMD_READ, 28'hFFFFFFF, 8'd2);
        serve_read_sector(28'hFFFFFFF, -1, 1'b0, ab);
        host_drain(1'b1);
        serve_read_sector(28'h0000000, -1, 1'b0, ab);
        host_drain(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 2) begin
            errors++;
            $display("FAIL read_wrap_irqs: %0d pulses, want 2", irq_cnt - irq0);
        end
    endtask

    // Three sectors with a stray command between them, then an immediate follow-up read.
    task automatic test_back_to_back();
        logic [27:0] lba = 28'($urandom);
        logic [27:0] lba2 = 28'($urandom);
        int          irq0 = irq_cnt;
        bit          ab;
        issue_cmd(CMD_READ, lba, 8'd3);
        for (int s = 0; s < 3; s++) begin
            serve_read_sector(28'(lba + 28'(s)), -1, 1'b0, ab);
            issue_cmd(8'hEC, 28'h0, 8'd1);
            checks++;
            if (err !== 1'b0 || drq !== 1'b1 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL busy_cmd_ignored: err=%b drq=%b bsy=%b, want 0 1 1", err, drq, bsy);
            end
            host_drain(s < 2);
        end
        issue_cmd(CMD_READ, lba2, 8'd1);
        serve_read_sector(lba2, -1, 1'b0, ab);
        host_drain(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 4) begin
            errors++;
            $display("FAIL back_to_back_irqs: %0d pulses, want 4", irq_cnt - irq0);
        end
    endtask

    task automatic test_bad_opcode();
        int irq0 = irq_cnt;
        bit bad = 1'b0;
        bit ab;
        issue_cmd(8'hEC, 28'($urandom), 8'd1);
        checks++;
        if (err !== 1'b1 || bsy !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL bad_op: err=%b bsy=%b irq=%b, want 1 0 1", err, bsy, irq);
        end
        repeat (20) begin
            @(negedge clk);
            if (st_req !== 1'b0 || bsy !== 1'b0 || drq !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || irq_cnt - irq0 != 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL bad_op_quiet: activity=%b irqs=%0d err=%b, want 0 1 1", bad, irq_cnt - irq0, err);
        end
        issue_cmd(CMD_READ, 28'h0000042, 8'd1);
        checks++;
        if (err !== 1'b0 || bsy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b bsy=%b, want 0 1", err, bsy);
        end
        serve_read_sector(28'h0000042, -1, 1'b0, ab);
        host_drain(1'b0);
    endtask

    task automatic test_read_st_err();
        int irq0 = irq_cnt;
        bit bad = 1'b0;
        bit ab;
        issue_cmd(CMD_READ, 28'h0ABCDEF, 8'd2);
        serve_read_sector(28'h0ABCDEF, 300, 1'b0, ab);
        checks++;
        if (!ab || bsy !== 1'b0 || err !== 1'b1 || irq !== 1'b1 || drq !== 1'b0 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL st_err_abort: aborted=%b bsy=%b err=%b irq=%b drq=%b st_req=%b, want 1 0 1 1 0 0",
                     ab, bsy, err, irq, drq, st_req);
        end
        repeat (10) begin
            @(negedge clk);
            if (drq !== 1'b0 || st_req !== 1'b0 || bsy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || irq_cnt - irq0 != 1) begin
            errors++;
            $display("FAIL st_err_after: activity=%b irqs=%0d, want 0 1", bad, irq_cnt - irq0);
        end
    endtask

    task automatic test_write();
        logic [27:0] lba = 28'($urandom);
        int          irq0 = irq_cnt;
        issue_cmd(CMD_WRITE, lba, 8'd2);
        checks++;
        if (drq !== 1'b1 || bsy !== 1'b1 || err !== 1'b0 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL write_start: drq=%b bsy=%b err=%b st_req=%b, want 1 1 0 0", drq, bsy, err, st_req);
        end
        for (int s = 0; s < 2; s++) begin
            host_fill(s == 0);
            host_drain(1'b1);
            serve_write_sector(28'(lba + 28'(s)));
            commit_sector(s == 1, irq0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 1) begin
            errors++;
            $display("FAIL write_irqs: %0d pulses, want 1", irq_cnt - irq0);
        end
    endtask

    task automatic test_reset_mid_write_then_count0();
        logic [27:0] lba = 28'($urandom);
        int          got = 0;
        int          n = 0;
        int          irq0;
        bit          ab;
        bit          idle_early = 1'b0;
        issue_cmd(CMD_WRITE, 28'h1234567, 8'd1);
        host_fill(1'b0);
        host_drain(1'b1);
        wait_req();
        st_ack = 1'b1;
        @(negedge clk);
        st_ack = 1'b0;
        while (n < 2000 && !(got >= 40 && st_wr_valid === 1'b1)) begin
            st_wr_ready = 1'($urandom_range(1));
            if (st_wr_valid === 1'b1 && st_wr_ready) got++;
            @(negedge clk);
            n++;
        end
        st_wr_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (st_wr_valid !== 1'b0 || bsy !== 1'b0 || ram_addr !== 9'd0 || drq !== 1'b0 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write: wr_valid=%b bsy=%b ram_addr=%0d drq=%b st_req=%b, want 0 0 0 0 0",
                     st_wr_valid, bsy, ram_addr, drq, st_req);
        end
        irq0 = irq_cnt;
        issue_cmd(CMD_READ, lba, 8'd0);
        for (int s = 0; s < 4; s++) begin
            serve_read_sector(28'(lba + 28'(s)), -1, 1'b0, ab);
            host_drain(1'b1);
            if (bsy !== 1'b1) idle_early = 1'b1;
        end
        serve_read_sector(28'(lba + 28'd4), 10, 1'b0, ab);
        checks++;
        if (idle_early || !ab || err !== 1'b1 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL count0_read: idle_early=%b aborted=%b err=%b bsy=%b, want 0 1 1 0",
                     idle_early, ab, err, bsy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 5) begin
            errors++;
            $display("FAIL count0_irqs: %0d pulses, want 5", irq_cnt - irq0);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 8'h00; cmd_lba = '0; cmd_count = 8'd0;
        host_done = 1'b0; st_ack = 1'b0; st_rd_valid = 1'b0; st_rd_data = 8'h00;
        st_wr_ready = 1'b0; st_done = 1'b0; st_err = 1'b0; fill_pulse = 1'b0;
        test_reset();
        test_read_basic();
        test_read_lba_wrap();
        test_back_to_back();
        test_bad_opcode();
        test_read_st_err();
        test_write();
        test_reset_mid_write_then_count0();
        repeat (2) @(negedge clk);
        checks++;
        if (irq_wide != 0) begin
            errors++;
            $display("FAIL irq_width: %0d cycles with irq held over, want 0", irq_wide);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
